router_ctrl: RTL and testbench
==============================

# router_ctrl

Packet-sequencing controller for the 1x3 router. Decodes the destination from the header byte and walks each packet through header, payload, parity and FIFO-full recovery. It drives the phase strobes consumed by the router register block and the per-port FIFO write enables. It also tracks per-port read timeouts and soft-resets a stalled output FIFO.

## Interface
- TIMEOUT, 30: consecutive unread-valid cycles before a port's soft reset fires (≥2).
- router_clock  in  1  sole clock; all state changes on rising edge.
- resetn  in  1  reset, synchronous, active-low.
- pkt_valid  in  1  source asserts for header and payload bytes; deasserts on the parity byte.
- data_in  in  2  header address bits data_in[1:0]; 0..2 are valid ports, 3 is invalid.
- fifo_empty  in  3  per-port FIFO empty.
- fifo_full_in  in  3  per-port FIFO full.
- read_enb  in  3  per-port destination read strobes.
- parity_done  in  1  from the register block.
- low_pkt_valid  in  1  from the register block.
- detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg  out  1 each  phase strobes to the register block.
- write_enb_reg  out  1  datapath byte is to be written.
- write_enb  out  3  one-hot write_enb_reg steered to the latched port.
- fifo_full  out  1  fifo_full_in[latched port].
- busy  out  1  source must hold data_in.
- vld_out  out  3  ~fifo_empty.
- soft_reset  out  3  one-cycle per-port FIFO soft reset.

## Operation
- **Registered state.** The state register and the 2-bit address latch are the only registered state, plus the timeout counters. All strobes are Moore decodes of the state.
- **Address latch.** Loads data_in[1:0] when detect_add && pkt_valid && data_in[1:0]!=3.
- **States and outputs:**
  - DECODE_ADDRESS: detect_add=1.
    - pkt_valid with valid addr a and fifo_empty[a] → LOAD_FIRST_DATA.
    - pkt_valid with valid addr a and !fifo_empty[a] → WAIT_TILL_EMPTY.
    - Otherwise, including addr 3, stay.
  - LOAD_FIRST_DATA: lfd_state=1, busy=1 → LOAD_DATA.
  - LOAD_DATA: ld_state=1, write_enb_reg=1, busy=0.
    - fifo_full → FIFO_FULL_STATE.
    - Else !pkt_valid → LOAD_PARITY.
    - Else stay.
  - LOAD_PARITY: write_enb_reg=1, busy=1 → CHECK_PARITY_ERROR.
  - CHECK_PARITY_ERROR: rst_int_reg=1, busy=1. fifo_full → FIFO_FULL_STATE, else → DECODE_ADDRESS.
  - FIFO_FULL_STATE: full_state=1, busy=1, write_enb_reg=0. !fifo_full → LOAD_AFTER_FULL.
  - LOAD_AFTER_FULL: laf_state=1, busy=1, write_enb_reg=1.
    - parity_done → DECODE_ADDRESS.
    - Else low_pkt_valid → LOAD_PARITY.
    - Else → LOAD_DATA.
  - WAIT_TILL_EMPTY: busy=1. fifo_empty[latched] → LOAD_FIRST_DATA.
- **Strobe exclusivity.** Exactly one of the six phase strobes is high in any phase-strobe state. LOAD_PARITY and WAIT_TILL_EMPTY assert none of them.
- **Soft reset of the active port** takes priority over all other transitions. If soft_reset[latched] is high in any state other than DECODE_ADDRESS, the next state is DECODE_ADDRESS.
- **write_enb.** write_enb[i] = write_enb_reg && latched==i. It is never more than one-hot.

## Timing
- **Reset.** resetn low at a rising edge puts the state in DECODE_ADDRESS, the address latch at 0 and all counters at 0.
  - After the edge: detect_add=1; every other strobe, busy, write_enb_reg and write_enb are 0; soft_reset=000.
  - Reset mid-packet abandons the packet with no write pulse afterward.
- **Latency.** The header is accepted at edge N, lfd_state is high in cycle N+1 and the first payload write occurs in cycle N+2.
- **Timeout counters.** Per port i, the counter increments each cycle vld_out[i] && !read_enb[i] and clears on read_enb[i] or !vld_out[i].
  - At count TIMEOUT-1 with the condition still true: soft_reset[i]=1 for the next cycle and the counter returns to 0.
  - A persistent stall therefore pulses every TIMEOUT cycles.
- **Simultaneous events.**
  - read_enb in the same cycle the count would expire: no pulse.
  - Soft reset on a non-latched port does not affect the FSM.

## Configuration
- ROUTER_SOFT_RST_EN
  - Defined: the timeout counters and soft-reset priority transitions are built as described.
  - Undefined: no counters; soft_reset is tied to 000, and the FSM ignores soft reset.

## Test plan
- **Header to empty port.** Reset, then header 0x05 (addr 1) with pkt_valid, all FIFOs empty:
  - lfd_state is high one cycle after the header.
  - write_enb=010 during the payload.
  - !pkt_valid leads to LOAD_PARITY, then a rst_int_reg pulse, then detect_add.
- **Busy port.** Header addr 2 with fifo_empty[2]=0:
  - busy=1, no strobe, write_enb=000.
  - Dropping fifo_empty[2] to 1 gives lfd_state the next cycle.
- **Invalid address.** Header addr 3: stays in DECODE_ADDRESS, address latch unchanged, no write_enb.
- **Full mid-payload.** fifo_full_in[0] rises during LOAD_DATA:
  - full_state=1 with write_enb_reg=0 until it falls.
  - Then laf_state for one cycle.
  - Then LOAD_DATA (low_pkt_valid=0) or LOAD_PARITY (low_pkt_valid=1).
- **Timeout (ROUTER_SOFT_RST_EN, TIMEOUT=30).** fifo_empty[1]=0 with read_enb=0:
  - soft_reset[1] pulses in cycle 31 and again in cycle 61.
  - A read_enb at cycle 29 suppresses the pulse.
  - A soft reset while port 1 is the active destination forces detect_add=1 next cycle.
- **Reset mid-packet.** Assert resetn=0 during LOAD_DATA: next cycle detect_add=1, write_enb=000, busy=0.

Source files
------------

// File: rtl/router_ctrl_if.sv
// Bundle of the signals exchanged between router_ctrl and the rest of the 1x3 router.
//   master : source / register block / FIFO side. It drives the packet and FIFO status
//            inputs and observes the controller outputs.
//   slave  : router_ctrl side. It receives packet and FIFO status, and drives the phase
//            strobes, write enables, busy, vld_out and soft_reset.
interface router_ctrl_if;
    logic       pkt_valid;
    logic [1:0] data_in;
    logic [2:0] fifo_empty;
    logic [2:0] fifo_full_in;
    logic [2:0] read_enb;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_add;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       rst_int_reg;
    logic       write_enb_reg;
    logic [2:0] write_enb;
    logic       fifo_full;
    logic       busy;
    logic [2:0] vld_out;
    logic [2:0] soft_reset;

    modport master (
        output pkt_valid, data_in, fifo_empty, fifo_full_in, read_enb, parity_done,
               low_pkt_valid,
        input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, write_enb, fifo_full, busy, vld_out, soft_reset
    );

    modport slave (
        input  pkt_valid, data_in, fifo_empty, fifo_full_in, read_enb, parity_done,
               low_pkt_valid,
        output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
               write_enb_reg, write_enb, fifo_full, busy, vld_out, soft_reset
    );
endinterface

// File: rtl/router_ctrl.sv
// Packet-sequencing controller for the 1x3 router.
// Decodes the header address, walks each packet through header, payload, parity and
// FIFO-full recovery, and drives the phase strobes and per-port FIFO write enables.
//
// Ports:
//   router_clock : sole clock, rising edge
//   resetn       : synchronous active-low reset
//   bus          : router_ctrl_if.slave
//                  (packet/FIFO status in; phase strobes, write enables, busy, vld_out,
//                  soft_reset out)
//
// Optional feature (macro ROUTER_SOFT_RST_EN):
//   When it is defined, per-port read-timeout counters are built. A port whose output is
//   valid but unread for TIMEOUT cycles gets a one-cycle soft_reset. A soft reset on the
//   latched port aborts the packet in flight.
//   When it is undefined, soft_reset is tied to 000 and the FSM never sees it.
module router_ctrl #(
    parameter int unsigned TIMEOUT = 30
) (
    input logic          router_clock,
    input logic          resetn,
    router_ctrl_if.slave bus
);

    localparam logic [2:0] DecodeAddress    = 3'd0;
    localparam logic [2:0] LoadFirstData    = 3'd1;
    localparam logic [2:0] LoadData         = 3'd2;
    localparam logic [2:0] LoadParity       = 3'd3;
    localparam logic [2:0] CheckParityError = 3'd4;
    localparam logic [2:0] FifoFullState    = 3'd5;
    localparam logic [2:0] LoadAfterFull    = 3'd6;
    localparam logic [2:0] WaitTillEmpty    = 3'd7;

    logic [2:0] state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic       addr_ok;
    logic       hdr_accept;
    logic       soft_rst_active;
    logic [2:0] vld;

    assign vld         = ~bus.fifo_empty;
    assign bus.vld_out = vld;
    assign addr_ok     = (bus.data_in != 2'd3);
    assign hdr_accept  = (state_q == DecodeAddress) && bus.pkt_valid && addr_ok;
    assign bus.fifo_full = bus.fifo_full_in[addr_q];

`ifdef ROUTER_SOFT_RST_EN
    localparam int unsigned CntW = $clog2(TIMEOUT);

    logic [CntW-1:0] cnt_q [3];
    logic [CntW-1:0] cnt_d [3];
    logic [2:0]      soft_reset_q, soft_reset_d;

    // A port stalls while it has valid data that nobody reads. A read or an empty FIFO
    // restarts the count, so a read in the expiring cycle suppresses the pulse.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]        = '0;
            soft_reset_d[i] = 1'b0;
            if (vld[i] && !bus.read_enb[i]) begin
                if (cnt_q[i] == CntW'(TIMEOUT - 1)) begin
                    soft_reset_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge router_clock) begin
        if (!resetn) begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
            soft_reset_q <= 3'b000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            soft_reset_q <= soft_reset_d;
        end
    end

    assign bus.soft_reset  = soft_reset_q;
    assign soft_rst_active = soft_reset_q[addr_q];
`else
    logic [34:0] unused_cfg;

    assign unused_cfg      = {bus.read_enb, TIMEOUT};
    assign bus.soft_reset  = 3'b000;
    assign soft_rst_active = 1'b0;
`endif

    // Only valid port numbers are ever latched, so addr_q never reaches 3.
    assign addr_d = hdr_accept ? bus.data_in : addr_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            DecodeAddress: begin
                if (hdr_accept) begin
                    state_d = bus.fifo_empty[bus.data_in] ? LoadFirstData : WaitTillEmpty;
                end
            end
            LoadFirstData: state_d = LoadData;
            LoadData: begin
                if (bus.fifo_full) begin
                    state_d = FifoFullState;
                end else if (!bus.pkt_valid) begin
                    state_d = LoadParity;
                end
            end
            LoadParity: state_d = CheckParityError;
            CheckParityError: state_d = bus.fifo_full ? FifoFullState : DecodeAddress;
            FifoFullState: begin
                if (!bus.fifo_full) begin
                    state_d = LoadAfterFull;
                end
            end
            LoadAfterFull: begin
                if (bus.parity_done) begin
                    state_d = DecodeAddress;
                end else if (bus.low_pkt_valid) begin
                    state_d = LoadParity;
                end else begin
                    state_d = LoadData;
                end
            end
            WaitTillEmpty: begin
                if (bus.fifo_empty[addr_q]) begin
                    state_d = LoadFirstData;
                end
            end
            default: state_d = DecodeAddress;
        endcase
        // A soft reset of the port being written overrides every other transition.
        if (soft_rst_active && (state_q != DecodeAddress)) begin
            state_d = DecodeAddress;
        end
    end

    always_ff @(posedge router_clock) begin
        if (!resetn) begin
            state_q <= DecodeAddress;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Moore decode of the phase strobes, busy and the datapath write enable.
    always_comb begin
        bus.detect_add    = 1'b0;
        bus.lfd_state     = 1'b0;
        bus.ld_state      = 1'b0;
        bus.laf_state     = 1'b0;
        bus.full_state    = 1'b0;
        bus.rst_int_reg   = 1'b0;
        bus.busy          = 1'b0;
        bus.write_enb_reg = 1'b0;
        case (state_q)
            DecodeAddress: bus.detect_add = 1'b1;
            LoadFirstData: begin
                bus.lfd_state = 1'b1;
                bus.busy      = 1'b1;
            end
            LoadData: begin
                bus.ld_state      = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            LoadParity: begin
                bus.busy          = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            CheckParityError: begin
                bus.rst_int_reg = 1'b1;
                bus.busy        = 1'b1;
            end
            FifoFullState: begin
                bus.full_state = 1'b1;
                bus.busy       = 1'b1;
            end
            LoadAfterFull: begin
                bus.laf_state     = 1'b1;
                bus.busy          = 1'b1;
                bus.write_enb_reg = 1'b1;
            end
            WaitTillEmpty: bus.busy = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            bus.write_enb[i] = bus.write_enb_reg && (addr_q == 2'(i));
        end
    end

endmodule

// File: tb/tb_router_ctrl.sv
// Scoreboard bench for router_ctrl. The stimulus pushes the expected output vector for
// each cycle it drives; a negedge monitor pops and compares against the DUT outputs.
module tb_router_ctrl;

    localparam int unsigned Timeout = 30;

    localparam int SDa  = 0;
    localparam int SLfd = 1;
    localparam int SLd  = 2;
    localparam int SLp  = 3;
    localparam int SCpe = 4;
    localparam int SFfs = 5;
    localparam int SLaf = 6;
    localparam int SWte = 7;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    router_ctrl_if bus ();

    router_ctrl #(
        .TIMEOUT (Timeout)
    ) dut (
        .router_clock (clk),
        .resetn       (resetn),
        .bus          (bus)
    );

    typedef struct {
        logic [17:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Vector layout: {detect_add, lfd, ld, laf, full, rst_int, busy, write_enb_reg,
    //                 write_enb[2:0], soft_reset[2:0], fifo_full, vld_out[2:0]}
    function automatic logic [17:0] expect_vec(input int st, input logic [1:0] a,
                                               input logic [2:0] sr, input logic ff,
                                               input logic [2:0] vld);
        logic [5:0] s;
        logic       b;
        logic       w;
        logic [2:0] we;
        case (st)
            SDa:     begin s = 6'b100000; b = 1'b0; w = 1'b0; end
            SLfd:    begin s = 6'b010000; b = 1'b1; w = 1'b0; end
            SLd:     begin s = 6'b001000; b = 1'b0; w = 1'b1; end
            SLp:     begin s = 6'b000000; b = 1'b1; w = 1'b1; end
            SCpe:    begin s = 6'b000001; b = 1'b1; w = 1'b0; end
            SFfs:    begin s = 6'b000010; b = 1'b1; w = 1'b0; end
            SLaf:    begin s = 6'b000100; b = 1'b1; w = 1'b1; end
            default: begin s = 6'b000000; b = 1'b1; w = 1'b0; end
        endcase
        we = w ? (3'b001 << a) : 3'b000;
        return {s, b, w, we, sr, ff, vld};
    endfunction

    // Expected outputs for the cycle now being driven, then advance one clock.
    task automatic step(input int st, input logic [1:0] a, input logic [2:0] sr,
                        input string nm);
        exp_t e;
        e.v    = expect_vec(st, a, sr, bus.fifo_full_in[a], ~bus.fifo_empty);
        e.name = nm;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t        e;
        logic [17:0] act;
        if (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            act = {bus.detect_add, bus.lfd_state, bus.ld_state, bus.laf_state,
                   bus.full_state, bus.rst_int_reg, bus.busy, bus.write_enb_reg,
                   bus.write_enb, bus.soft_reset, bus.fifo_full, bus.vld_out};
            checks++;
            if (act !== e.v) begin
                failures++;
                $display("FAIL %s: got %b required %b", e.name, act, e.v);
            end
        end
    end

`ifdef ROUTER_SOFT_RST_EN
    // Port 1 stalled for 2*Timeout+1 cycles; read_cycle (0 = none) pulses read_enb[1].
    task automatic stall_run(input int read_cycle, input int p1, input int p2,
                             input string nm);
        bus.fifo_empty = 3'b101;
        for (int c = 1; c <= 2 * Timeout + 1; c++) begin
            bus.read_enb = (c == read_cycle) ? 3'b010 : 3'b000;
            step(SDa, 2'd0, ((c == p1) || (c == p2)) ? 3'b010 : 3'b000, nm);
        end
        bus.read_enb   = 3'b000;
        bus.fifo_empty = 3'b111;
        step(SDa, 2'd0, 3'b000, nm);
        step(SDa, 2'd0, 3'b000, nm);
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.pkt_valid     = 1'b0;
        bus.data_in       = 2'd0;
        bus.fifo_empty    = 3'b111;
        bus.fifo_full_in  = 3'b000;
        bus.read_enb      = 3'b000;
        bus.parity_done   = 1'b0;
        bus.low_pkt_valid = 1'b0;
        resetn            = 1'b0;
        @(posedge clk);
        #1;
        step(SDa, 2'd0, 3'b000, "reset");
        checks++;
        if (bus.detect_add !== 1'b1) begin
            failures++;
            $display("FAIL reset_detect_add: got %b", bus.detect_add);
        end
        checks++;
        if (bus.write_enb !== 3'b000) begin
            failures++;
            $display("FAIL reset_write_enb: got %b", bus.write_enb);
        end
        resetn = 1'b1;
        step(SDa, 2'd0, 3'b000, "idle");

        // Header 0x05 to empty port 1
        bus.data_in   = 2'd1;
        bus.pkt_valid = 1'b1;
        step(SDa,  2'd0, 3'b000, "hdr1_accept");
        checks++;
        if (bus.lfd_state !== 1'b1) begin
            failures++;
            $display("FAIL hdr1_lfd_direct: got %b", bus.lfd_state);
        end
        step(SLfd, 2'd1, 3'b000, "hdr1_lfd");
        step(SLd,  2'd1, 3'b000, "hdr1_payload");
        bus.pkt_valid = 1'b0;
        step(SLd,  2'd1, 3'b000, "hdr1_last_payload");
        step(SLp,  2'd1, 3'b000, "hdr1_parity");
        step(SCpe, 2'd1, 3'b000, "hdr1_rst_int");
        step(SDa,  2'd1, 3'b000, "hdr1_done");

        // Busy port 2
        bus.fifo_empty = 3'b011;
        bus.data_in    = 2'd2;
        bus.pkt_valid  = 1'b1;
        step(SDa,  2'd1, 3'b000, "busy_hdr");
        bus.pkt_valid = 1'b0;
        step(SWte, 2'd2, 3'b000, "busy_wait");
        step(SWte, 2'd2, 3'b000, "busy_wait");
        bus.fifo_empty = 3'b111;
        step(SWte, 2'd2, 3'b000, "busy_release");
        step(SLfd, 2'd2, 3'b000, "busy_lfd");
        step(SLd,  2'd2, 3'b000, "busy_payload");
        step(SLp,  2'd2, 3'b000, "busy_parity");
        step(SCpe, 2'd2, 3'b000, "busy_rst_int");
        step(SDa,  2'd2, 3'b000, "busy_done");

        // Invalid address 3: latch must still hold 2 (visible through fifo_full)
        bus.data_in   = 2'd3;
        bus.pkt_valid = 1'b1;
        step(SDa, 2'd2, 3'b000, "inv_addr");
        step(SDa, 2'd2, 3'b000, "inv_addr");
        bus.fifo_full_in = 3'b100;
        step(SDa, 2'd2, 3'b000, "inv_latch");
        bus.fifo_full_in = 3'b000;

        // Full mid-payload on port 0
        bus.data_in = 2'd0;
        step(SDa,  2'd2, 3'b000, "full_hdr");
        step(SLfd, 2'd0, 3'b000, "full_lfd");
        step(SLd,  2'd0, 3'b000, "full_payload");
        bus.fifo_full_in = 3'b001;
        step(SLd,  2'd0, 3'b000, "full_rise");
        step(SFfs, 2'd0, 3'b000, "full_hold");
        step(SFfs, 2'd0, 3'b000, "full_hold");
        bus.fifo_full_in = 3'b000;
        step(SFfs, 2'd0, 3'b000, "full_fall");
        step(SLaf, 2'd0, 3'b000, "laf");
        step(SLd,  2'd0, 3'b000, "laf_to_ld");
        bus.fifo_full_in = 3'b001;
        step(SLd,  2'd0, 3'b000, "full_rise2");
        step(SFfs, 2'd0, 3'b000, "full_hold2");
        bus.fifo_full_in  = 3'b000;
        bus.low_pkt_valid = 1'b1;
        step(SFfs, 2'd0, 3'b000, "full_fall2");
        step(SLaf, 2'd0, 3'b000, "laf2");
        bus.low_pkt_valid = 1'b0;
        bus.pkt_valid     = 1'b0;
        step(SLp,  2'd0, 3'b000, "laf_to_lp");
        step(SCpe, 2'd0, 3'b000, "full_rst_int");
        step(SDa,  2'd0, 3'b000, "full_done");

        // Reset mid-packet
        bus.data_in   = 2'd1;
        bus.pkt_valid = 1'b1;
        step(SDa,  2'd0, 3'b000, "rst_hdr");
        step(SLfd, 2'd1, 3'b000, "rst_lfd");
        step(SLd,  2'd1, 3'b000, "rst_payload");
        resetn = 1'b0;
        step(SLd,  2'd1, 3'b000, "rst_assert");
        checks++;
        if (bus.detect_add !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid_detect_add: got %b", bus.detect_add);
        end
        checks++;
        if (bus.write_enb !== 3'b000) begin
            failures++;
            $display("FAIL rst_mid_write_enb: got %b", bus.write_enb);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_busy: got %b", bus.busy);
        end
        resetn        = 1'b1;
        bus.pkt_valid = 1'b0;
        step(SDa,  2'd0, 3'b000, "rst_mid");
        step(SDa,  2'd0, 3'b000, "rst_idle");

`ifdef ROUTER_SOFT_RST_EN
        stall_run(0,  Timeout + 1, 2 * Timeout + 1, "to_stall");
        stall_run(29, 2 * Timeout, 0, "to_read29");
        stall_run(30, 2 * Timeout + 1, 0, "to_read30");

        // Soft reset of the active port aborts the wait
        bus.fifo_empty = 3'b101;
        bus.data_in    = 2'd1;
        bus.pkt_valid  = 1'b1;
        step(SDa, 2'd0, 3'b000, "sr_hdr");
        bus.pkt_valid = 1'b0;
        for (int c = 2; c <= Timeout; c++) begin
            step(SWte, 2'd1, 3'b000, "sr_wait");
        end
        step(SWte, 2'd1, 3'b010, "sr_pulse");
        bus.fifo_empty = 3'b111;
        step(SDa, 2'd1, 3'b000, "sr_abort");
`else
        // Without the feature a long stall never resets the port
        bus.fifo_empty = 3'b101;
        bus.data_in    = 2'd1;
        bus.pkt_valid  = 1'b1;
        step(SDa, 2'd0, 3'b000, "nosr_hdr");
        bus.pkt_valid = 1'b0;
        for (int c = 2; c <= Timeout + 10; c++) begin
            step(SWte, 2'd1, 3'b000, "nosr_wait");
        end
        bus.fifo_empty = 3'b111;
        step(SWte, 2'd1, 3'b000, "nosr_release");
        step(SLfd, 2'd1, 3'b000, "nosr_lfd");
        step(SLd,  2'd1, 3'b000, "nosr_payload");
        step(SLp,  2'd1, 3'b000, "nosr_parity");
        step(SCpe, 2'd1, 3'b000, "nosr_rst_int");
        step(SDa,  2'd1, 3'b000, "nosr_done");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
